// File: rtl/ula_arbiter.sv
// Round-robin arbiter sharing one combinational ULA between the execute stage (0)
// and the address/aux unit (1); returns the captured result with zero/neg/err flags.
module ula_arbiter #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 1,
    parameter int INIT_PRIO     = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [4:0]       req0_opcode,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [4:0]       req1_opcode,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic             rsp_neg,
    output logic             rsp_err,
    output logic [WIDTH-1:0] ula_a,
    output logic [WIDTH-1:0] ula_b,
    output logic [4:0]       ula_opcode,
    input  logic [WIDTH-1:0] ula_out
);

    localparam logic [4:0] OP_NOP      = 5'b10000;
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic       INIT_LAST   = (INIT_PRIO == 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    state_t           state_r;
    logic [3:0]       cnt_r;
    logic             last_grant_r;
    logic [4:0]       op_r;
    logic             id_r;

    logic             grant_s;
    logic             idle_s;
    logic             accept_s;
    logic [4:0]       sel_op_s;
    logic [WIDTH-1:0] sel_a_s;
    logic [WIDTH-1:0] sel_b_s;
    logic [WIDTH-1:0] cap_result_s;

    // Opcodes that have no encoding in the ULA
    function automatic logic op_unimpl(input logic [4:0] op);
        case (op)
            5'b00010, 5'b00111,
            5'b01010, 5'b01011, 5'b01100,
            5'b01101, 5'b01110, 5'b01111: op_unimpl = 1'b1;
            default:                      op_unimpl = 1'b0;
        endcase
    endfunction

    // Round-robin pick: a tie goes to the requester that did not win last time
    always_comb begin
        grant_s = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_s = ~last_grant_r;
        end else if (req1_valid) begin
            grant_s = 1'b1;
        end else begin
            grant_s = 1'b0;
        end
    end

    assign idle_s     = (state_r == ST_IDLE) && !reset;
    assign req0_ready = idle_s && req0_valid && (grant_s == 1'b0);
    assign req1_ready = idle_s && req1_valid && (grant_s == 1'b1);
    assign accept_s   = req0_ready || req1_ready;

    // Operand mux for the requester being granted
    always_comb begin
        sel_op_s = req0_opcode;
        sel_a_s  = req0_a;
        sel_b_s  = req0_b;
        if (grant_s) begin
            sel_op_s = req1_opcode;
            sel_a_s  = req1_a;
            sel_b_s  = req1_b;
        end else begin
            sel_op_s = req0_opcode;
            sel_a_s  = req0_a;
            sel_b_s  = req0_b;
        end
    end

    // NOP and unencoded opcodes never forward whatever the ULA drives
    always_comb begin
        cap_result_s = ula_out;
        if ((op_r == OP_NOP) || op_unimpl(op_r)) begin
            cap_result_s = {WIDTH{1'b0}};
        end else begin
            cap_result_s = ula_out;
        end
    end

    // Issue/settle/respond sequencer with registered ULA drive and response
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= 4'd0;
            last_grant_r <= INIT_LAST;
            op_r         <= OP_NOP;
            id_r         <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
            rsp_result   <= {WIDTH{1'b0}};
            rsp_zero     <= 1'b0;
            rsp_neg      <= 1'b0;
            rsp_err      <= 1'b0;
            ula_a        <= {WIDTH{1'b0}};
            ula_b        <= {WIDTH{1'b0}};
            ula_opcode   <= OP_NOP;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        op_r         <= sel_op_s;
                        id_r         <= grant_s;
                        last_grant_r <= grant_s;
                        ula_a        <= sel_a_s;
                        ula_b        <= sel_b_s;
                        ula_opcode   <= sel_op_s;
                        cnt_r        <= 4'd0;
                        state_r      <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (cnt_r == SETTLE_LAST) begin
                        rsp_result <= cap_result_s;
                        rsp_zero   <= (cap_result_s == {WIDTH{1'b0}});
                        rsp_neg    <= cap_result_s[WIDTH-1];
                        rsp_err    <= op_unimpl(op_r);
                        rsp_id     <= id_r;
                        rsp_valid  <= 1'b1;
                        ula_opcode <= OP_NOP;
                        state_r    <= ST_RESP;
                    end else begin
                        cnt_r <= cnt_r + 4'd1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid  <= 1'b0;
                    ula_opcode <= OP_NOP;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
